// File: rtl/micro_mult_seq.sv
// Sequential shift-add multiplier: one partial-product step per enabled clock,
// registered 2*WIDTH product plus a byte-selectable view for 8-bit output pins.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; prod holds last result
// RUN    | shift-add steps in progress, busy high
// DONE   | prod just updated, done high; may accept a new start
module micro_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    input  logic                 byte_sel,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod,
    output logic [7:0]           out_byte
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] mcand_q;
    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    prod_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH:0]   sum_d;
    logic [PW-1:0]    acc_d;
    logic [WIDTH-1:0] addend;
    logic [31:0]      prod_ext;

    // Multiplier lives in the low half of the accumulator and is consumed LSB first.
    always_comb begin
        addend   = acc_q[0] ? mcand_q : {WIDTH{1'b0}};
        sum_d    = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, addend};
        acc_d    = {sum_d, acc_q[WIDTH-1:1]};
        prod_ext = 32'(prod_q);
        out_byte = byte_sel ? prod_ext[15:8] : prod_ext[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (ena) begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                    if (start) begin
                        mcand_q <= a_in;
                        acc_q   <= {{WIDTH{1'b0}}, b_in};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        prod_q  <= acc_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign prod = prod_q;

endmodule

// File: tb/tb_micro_mult_seq.sv
// Self-checking bench for micro_mult_seq: directed vector table, hand-written
// handshake corner cases, and randomized operands with random ena stalls.
module tb_micro_mult_seq;

    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic           ena;
    logic           start;
    logic [W-1:0]   a_in;
    logic [W-1:0]   b_in;
    logic           byte_sel;
    logic           busy;
    logic           done;
    logic [2*W-1:0] prod;
    logic [7:0]     out_byte;

    int n_checks = 0;
    int n_pass   = 0;

    micro_mult_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .byte_sel (byte_sel),
        .busy     (busy),
        .done     (done),
        .prod     (prod),
        .out_byte (out_byte)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp_prod;
        logic [7:0]  exp_lo;
        logic [7:0]  exp_hi;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept an operation at the next edge, then wait for done; reports the
    // number of edges after acceptance and how many samples busy was high.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output int edges, output int busy_cnt);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 0;
        busy_cnt = 0;
        while (!done && edges < 100) begin
            if (busy) busy_cnt++;
            tick();
            edges++;
        end
    endtask

    int edges, bcnt, dcount, en_edges, guard;
    logic [7:0]  ra, rb;
    logic [31:0] exp_p;
    logic        ena_was;

    initial begin
        vecs[0] = '{8'd13,  8'd11,  16'h008F, 8'h8F, 8'h00};
        vecs[1] = '{8'd255, 8'd255, 16'hFE01, 8'h01, 8'hFE};
        vecs[2] = '{8'd0,   8'd200, 16'h0000, 8'h00, 8'h00};
        vecs[3] = '{8'd1,   8'd255, 16'h00FF, 8'hFF, 8'h00};
        vecs[4] = '{8'd128, 8'd2,   16'h0100, 8'h00, 8'h01};
        vecs[5] = '{8'd170, 8'd85,  16'h3872, 8'h72, 8'h38};

        rst_n = 1'b0; ena = 1'b1; start = 1'b0;
        a_in = '0; b_in = '0; byte_sel = 1'b0;
        #12;
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_prod", 32'(prod), 0);
        check("reset_out_byte", 32'(out_byte), 0);
        rst_n = 1'b1;
        tick();

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, edges, bcnt);
            check($sformatf("vec%0d_latency", i), 32'(edges), W);
            check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), W);
            check($sformatf("vec%0d_prod", i), 32'(prod), 32'(vecs[i].exp_prod));
            byte_sel = 1'b0; #1;
            check($sformatf("vec%0d_lo", i), 32'(out_byte), 32'(vecs[i].exp_lo));
            byte_sel = 1'b1; #1;
            check($sformatf("vec%0d_hi", i), 32'(out_byte), 32'(vecs[i].exp_hi));
            byte_sel = 1'b0;
            tick();
            check($sformatf("vec%0d_done_pulse", i), 32'(done), 0);
        end

        // Busy collision: second start during RUN is ignored
        a_in = 8'd3; b_in = 8'd5; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        a_in = 8'd7; b_in = 8'd7; start = 1'b1;
        tick();
        start = 1'b0;
        check("collision_busy", 32'(busy), 1);
        for (int k = 4; k <= 8; k++) tick();
        check("collision_done", 32'(done), 1);
        check("collision_prod", 32'(prod), 15);
        dcount = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done) dcount++;
        end
        check("collision_no_second_done", 32'(dcount), 0);
        check("collision_idle_busy", 32'(busy), 0);

        // Back-to-back: start held, new operands presented in DONE cycle
        a_in = 8'd2; b_in = 8'd3; start = 1'b1;
        tick();
        for (int k = 1; k <= 8; k++) tick();
        check("b2b_first_done", 32'(done), 1);
        check("b2b_first_prod", 32'(prod), 6);
        a_in = 8'd4; b_in = 8'd4;
        tick();
        start = 1'b0;
        check("b2b_restart_busy", 32'(busy), 1);
        check("b2b_restart_done_low", 32'(done), 0);
        for (int k = 10; k <= 12; k++) tick();
        check("b2b_prod_held", 32'(prod), 6);
        for (int k = 13; k <= 17; k++) tick();
        check("b2b_second_done", 32'(done), 1);
        check("b2b_second_prod", 32'(prod), 16);
        tick();

        // Stall: ena low for 3 edges mid-RUN, then low again while in DONE
        a_in = 8'd9; b_in = 8'd9; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        ena = 1'b0;
        tick(); tick(); tick();
        ena = 1'b1;
        check("stall_busy_held", 32'(busy), 1);
        for (int k = 7; k <= 10; k++) tick();
        check("stall_not_done_early", 32'(done), 0);
        tick();
        check("stall_done", 32'(done), 1);
        check("stall_prod", 32'(prod), 81);
        ena = 1'b0;
        tick(); tick();
        check("stall_done_held", 32'(done), 1);
        check("stall_done_busy", 32'(busy), 0);
        ena = 1'b1;
        tick();
        check("stall_done_release", 32'(done), 0);

        // Asynchronous reset mid-operation
        a_in = 8'd200; b_in = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        check("areset_busy", 32'(busy), 0);
        check("areset_done", 32'(done), 0);
        check("areset_prod", 32'(prod), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("areset_no_done", 32'(done), 0);
        run_op(8'd6, 8'd7, edges, bcnt);
        check("areset_after_latency", 32'(edges), W);
        check("areset_after_prod", 32'(prod), 42);
        tick();

        // Randomized operands with random ena stalls against a*b
        for (int t = 0; t < 40; t++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            exp_p = 32'(ra) * 32'(rb);
            ena = 1'b1;
            a_in = ra; b_in = rb; start = 1'b1;
            tick();
            start = 1'b0;
            en_edges = 0;
            guard = 0;
            while (!done && guard < 200) begin
                ena = ($urandom_range(0, 3) != 0);
                a_in = 8'($urandom);
                b_in = 8'($urandom);
                ena_was = ena;
                tick();
                if (ena_was) en_edges++;
                guard++;
            end
            ena = 1'b1;
            check($sformatf("rand%0d_enabled_edges", t), 32'(en_edges), W);
            check($sformatf("rand%0d_prod", t), 32'(prod), exp_p);
            byte_sel = 1'($urandom);
            #1;
            check($sformatf("rand%0d_out_byte", t), 32'(out_byte),
                  byte_sel ? ((exp_p >> 8) & 32'hFF) : (exp_p & 32'hFF));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
